ups_ad_monitor: RTL and testbench

//  Consumes the 12-bit sample stream (data/dv) from the AD7476A SPI

---
 rtl/ups_pkg.sv | 18 +
 rtl/ups_ad_avg.sv | 46 ++++
 rtl/ups_ad_monitor.sv | 116 +++++++++++
 tb/tb_ups_ad_monitor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ups_pkg.sv
// Shared types and constants for the UPS ADC path and the power-fail monitor.
package ups_pkg;

  localparam int UPS_AD_W = 12;

  typedef enum logic [1:0] {
    MON_OK        = 2'd0,
    MON_LOW_PEND  = 2'd1,
    MON_FAIL      = 2'd2,
    MON_HIGH_PEND = 2'd3
  } mon_state_t;

  // Power is reported failed while in the fail state or while a recovery is pending.
  function automatic logic state_is_fail(input mon_state_t s);
    return (s == MON_FAIL) || (s == MON_HIGH_PEND);
  endfunction

endpackage

// File: rtl/ups_ad_avg.sv
// Box-car decimator: sums 2^AVG_LOG2 ADC samples and emits their truncated mean.
module ups_ad_avg
  import ups_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [UPS_AD_W-1:0] ad_data,
  input  logic                ad_dv,
  output logic [UPS_AD_W-1:0] avg_data,
  output logic                avg_dv
);

  // Wide enough for 2^AVG_LOG2 full-scale samples, so the sum never wraps.
  localparam int ACC_W = UPS_AD_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [AVG_LOG2-1:0] cnt;

  assign sum = acc + ACC_W'(ad_data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      avg_data <= '0;
      avg_dv   <= 1'b0;
    end else begin
      avg_dv <= 1'b0;
      if (ad_dv) begin
        if (cnt == '1) begin
          avg_data <= sum[ACC_W-1:AVG_LOG2];
          avg_dv   <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + AVG_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ups_ad_monitor.sv
// UPS input monitor: averages ADC samples, then applies hysteresis and debounce
// to decide the power-fail flag. Starts in the failed state.
module ups_ad_monitor
  import ups_pkg::*;
#(
  parameter int AVG_LOG2 = 3,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [UPS_AD_W-1:0] ad_data,
  input  logic                ad_dv,
  input  logic [UPS_AD_W-1:0] th_low,
  input  logic [UPS_AD_W-1:0] th_high,
  output logic [UPS_AD_W-1:0] avg_data,
  output logic                avg_dv,
  output logic                pwr_fail,
  output logic                pwr_fail_evt,
  output mon_state_t          mon_state
);

  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE);

  mon_state_t state, state_next;
  logic [3:0] deb, deb_next;
  logic       is_low, is_good;

  ups_ad_avg #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .ad_data  (ad_data),
    .ad_dv    (ad_dv),
    .avg_data (avg_data),
    .avg_dv   (avg_dv)
  );

  // Strict comparisons: hitting a threshold exactly never qualifies.
  assign is_low  = avg_data < th_low;
  assign is_good = avg_data > th_high;

  // The event pulse lines up with the first cycle of the new pwr_fail value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= MON_FAIL;
      deb          <= '0;
      pwr_fail_evt <= 1'b0;
    end else begin
      state        <= state_next;
      deb          <= deb_next;
      pwr_fail_evt <= state_is_fail(state_next) != state_is_fail(state);
    end
  end

  always_comb begin
    state_next = state;
    deb_next   = deb;
    if (avg_dv) begin
      case (state)
        MON_OK: begin
          if (is_low) begin
            if (DEB_MAX == 4'd1) begin
              state_next = MON_FAIL;
              deb_next   = '0;
            end else begin
              state_next = MON_LOW_PEND;
              deb_next   = 4'd1;
            end
          end
        end
        MON_LOW_PEND: begin
          if (!is_low) begin
            state_next = MON_OK;
            deb_next   = '0;
          end else if (deb + 4'd1 == DEB_MAX) begin
            state_next = MON_FAIL;
            deb_next   = '0;
          end else begin
            deb_next = deb + 4'd1;
          end
        end
        MON_FAIL: begin
          if (is_good) begin
            if (DEB_MAX == 4'd1) begin
              state_next = MON_OK;
              deb_next   = '0;
            end else begin
              state_next = MON_HIGH_PEND;
              deb_next   = 4'd1;
            end
          end
        end
        MON_HIGH_PEND: begin
          if (!is_good) begin
            state_next = MON_FAIL;
            deb_next   = '0;
          end else if (deb + 4'd1 == DEB_MAX) begin
            state_next = MON_OK;
            deb_next   = '0;
          end else begin
            deb_next = deb + 4'd1;
          end
        end
        default: begin
          state_next = MON_FAIL;
          deb_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pwr_fail  = state_is_fail(state);
    mon_state = state;
  end

endmodule

// File: tb/tb_ups_ad_monitor.sv
// Directed bench for ups_ad_monitor with AVG_LOG2=3, DEBOUNCE=4, th_low=0x800, th_high=0x900.
module tb_ups_ad_monitor;
  import ups_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ad_data = '0;
  logic        ad_dv = 1'b0;
  logic [11:0] th_low = 12'h800;
  logic [11:0] th_high = 12'h900;
  logic [11:0] avg_data;
  logic        avg_dv;
  logic        pwr_fail;
  logic        pwr_fail_evt;
  mon_state_t  mon_state;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [11:0] smp;
    mon_state_t  st;
    logic        fail;
    logic        evt;
  } vec_t;
  vec_t vecs[20];

  always #5 clk = ~clk;

  ups_ad_monitor #(.AVG_LOG2(3), .DEBOUNCE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ad_data      (ad_data),
    .ad_dv        (ad_dv),
    .th_low       (th_low),
    .th_high      (th_high),
    .avg_data     (avg_data),
    .avg_dv       (avg_dv),
    .pwr_fail     (pwr_fail),
    .pwr_fail_evt (pwr_fail_evt),
    .mon_state    (mon_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every avg_dv must match the next expected average.
  always @(negedge clk) begin
    if (rst_n && avg_dv) begin
      if (exp_q.size() == 0) check("avg_dv_unexpected", 32'd1, 32'd0);
      else check("sb_avg_data", 32'(avg_data), 32'(exp_q.pop_front()));
    end
  end

  // Event pulse must coincide with exactly the first cycle of each new pwr_fail value.
  logic prev_fail = 1'b1;
  logic live = 1'b0;
  always @(negedge clk) begin
    if (live && rst_n) check("evt_vs_fail", 32'(pwr_fail_evt), 32'(pwr_fail != prev_fail));
    prev_fail = pwr_fail;
    live = rst_n;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    ad_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_avg_data", 32'(avg_data), 32'h0);
    check("rst_flags", 32'({avg_dv, pwr_fail, pwr_fail_evt}), 32'b010);
    check("rst_state", 32'(mon_state), 32'(MON_FAIL));
  endtask

  // Drives n back-to-back strobes; returns 1 ns after the edge that took the last one.
  task automatic send_burst(input logic [11:0] d, input int n);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      ad_data = d;
      ad_dv = 1'b1;
      @(posedge clk); #1;
    end
    ad_dv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{12'h880, MON_FAIL,      1'b1, 1'b0};
    vecs[1]  = '{12'h880, MON_FAIL,      1'b1, 1'b0};
    vecs[2]  = '{12'hA00, MON_HIGH_PEND, 1'b1, 1'b0};
    vecs[3]  = '{12'hA00, MON_HIGH_PEND, 1'b1, 1'b0};
    vecs[4]  = '{12'hA00, MON_HIGH_PEND, 1'b1, 1'b0};
    vecs[5]  = '{12'hA00, MON_OK,        1'b0, 1'b1};
    vecs[6]  = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[7]  = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[8]  = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[9]  = '{12'h800, MON_OK,        1'b0, 1'b0};
    vecs[10] = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[11] = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[12] = '{12'h7FF, MON_LOW_PEND,  1'b0, 1'b0};
    vecs[13] = '{12'h7FF, MON_FAIL,      1'b1, 1'b1};
    vecs[14] = '{12'h900, MON_FAIL,      1'b1, 1'b0};
    vecs[15] = '{12'h900, MON_FAIL,      1'b1, 1'b0};
    vecs[16] = '{12'h901, MON_HIGH_PEND, 1'b1, 1'b0};
    vecs[17] = '{12'h901, MON_HIGH_PEND, 1'b1, 1'b0};
    vecs[18] = '{12'h900, MON_FAIL,      1'b1, 1'b0};
    vecs[19] = '{12'h901, MON_HIGH_PEND, 1'b1, 1'b0};

    // Reset with ADC idle: fail-safe outputs held for 100 cycles.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      check("idle_flags", 32'({avg_dv, pwr_fail, pwr_fail_evt}), 32'b010);
    end

    // Sparse samples 0..7: mean 28/8 truncates to 3, strobe one cycle after the 8th dv.
    exp_q.push_back(12'h003);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1 ad_data = 12'(i); ad_dv = 1'b1;
      @(posedge clk); #1 ad_dv = 1'b0;
      if (i < 7) repeat (14) @(posedge clk);
    end
    check("sparse_avg_dv", 32'(avg_dv), 32'd1);
    check("sparse_avg_data", 32'(avg_data), 32'h003);
    @(posedge clk); #1;
    check("sparse_avg_dv_single", 32'(avg_dv), 32'd0);

    // Full-scale back-to-back, then a second average whose first dv lands in the avg_dv cycle.
    exp_q.push_back(12'hFFF);
    exp_q.push_back(12'h010);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      ad_data = (i < 8) ? 12'hFFF : 12'h010;
      ad_dv = 1'b1;
      @(posedge clk); #1;
      if (i == 7) check("b2b_first_avg_dv", 32'(avg_dv), 32'd1);
      if (i == 8) check("b2b_no_double_dv", 32'(avg_dv), 32'd0);
    end
    ad_dv = 1'b0;
    check("b2b_second_avg_dv", 32'(avg_dv), 32'd1);
    check("b2b_second_avg_data", 32'(avg_data), 32'h010);
    repeat (2) @(posedge clk); #1;
    check("b2b_pwr_fail", 32'(pwr_fail), 32'd1);

    // Partial sum discarded by reset; the next average uses only post-reset samples.
    send_burst(12'hFFF, 5);
    do_reset();
    exp_q.push_back(12'h100);
    send_burst(12'h100, 8);
    check("post_rst_avg_dv", 32'(avg_dv), 32'd1);
    check("post_rst_avg_data", 32'(avg_data), 32'h100);
    @(posedge clk); #1;
    check("post_rst_pwr_fail", 32'(pwr_fail), 32'd1);

    // Table: one constant-valued average per row, checking latency, state and event.
    do_reset();
    for (int v = 0; v < 20; v++) begin
      exp_q.push_back(vecs[v].smp);
      send_burst(vecs[v].smp, 8);
      check($sformatf("vec%0d_avg_dv", v), 32'(avg_dv), 32'd1);
      check($sformatf("vec%0d_avg_data", v), 32'(avg_data), 32'(vecs[v].smp));
      check($sformatf("vec%0d_fail_unchanged", v), 32'(pwr_fail), 32'(v == 0 ? 1'b1 : vecs[v-1].fail));
      @(posedge clk); #1;
      check($sformatf("vec%0d_pwr_fail", v), 32'(pwr_fail), 32'(vecs[v].fail));
      check($sformatf("vec%0d_evt", v), 32'(pwr_fail_evt), 32'(vecs[v].evt));
      check($sformatf("vec%0d_state", v), 32'(mon_state), 32'(vecs[v].st));
      @(posedge clk); #1;
      check($sformatf("vec%0d_evt_off", v), 32'({avg_dv, pwr_fail_evt}), 32'b00);
    end

    repeat (4) @(posedge clk); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
